// File: rtl/index_select.sv
// Purpose: scan a reliability stream MSB-first and mark the first K reliable positions in an N-bit mask.
// Latency: one word per 1+W cycles; index_valid pulses one cycle after the final scan cycle.
// Backpressure: rel_ready_o is high only while waiting for a word; it stays low for the W scan cycles.
module index_select #(
    parameter int N = 450,
    parameter int W = 30,
    parameter int K = 256
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start_i,
    input  logic         rel_valid_i,
    output logic         rel_ready_o,
    input  logic [W-1:0] rel_data_i,
    output logic [N-1:0] index_o,
    output logic         index_valid_o,
    output logic [8:0]   sel_cnt_o,
    output logic         busy_o,
    output logic         fail_o
);

    localparam int NWORDS = N / W;

    // Sized compare constants keep the counter comparisons width-exact.
    localparam logic [8:0] K_C       = 9'(K);
    localparam logic [4:0] LAST_BIT  = 5'(W - 1);
    localparam logic [3:0] LAST_WORD = 4'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_SCAN      = 3'd2,
        S_DONE      = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t         state_q,       state_d;
    logic [N-1:0]   index_q,       index_d;
    logic [W-1:0]   word_q,        word_d;
    logic [8:0]     sel_cnt_q,     sel_cnt_d;
    logic [3:0]     word_cnt_q,    word_cnt_d;
    logic [4:0]     bit_cnt_q,     bit_cnt_d;
    logic           fail_q,        fail_d;
    logic           index_vld_q,   index_vld_d;
    logic           sel;

    // State and datapath registers; reset discards any partial mask.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            word_q      <= '0;
            sel_cnt_q   <= '0;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            fail_q      <= 1'b0;
            index_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            word_q      <= word_d;
            sel_cnt_q   <= sel_cnt_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            fail_q      <= fail_d;
            index_vld_q <= index_vld_d;
        end
    end

    // Next-state logic: accept a word, shift its bits into the mask one per cycle, then settle.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        word_d      = word_q;
        sel_cnt_d   = sel_cnt_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        fail_d      = fail_q;
        index_vld_d = 1'b0;
        rel_ready_o = 1'b0;
        sel         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    index_d    = '0;
                    sel_cnt_d  = '0;
                    fail_d     = 1'b0;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_WAIT_WORD;
                end
            end

            S_WAIT_WORD: begin
                rel_ready_o = 1'b1;
                if (rel_valid_i) begin
                    word_d    = rel_data_i;
                    bit_cnt_d = '0;
                    state_d   = S_SCAN;
                end
            end

            S_SCAN: begin
                // Once K positions are taken, further reliable bits still shift in as 0
                // so the first scanned position ends up at index[N-1].
                sel       = word_q[W-1] && (sel_cnt_q < K_C);
                index_d   = {index_q[N-2:0], sel};
                sel_cnt_d = sel_cnt_q + {8'd0, sel};
                word_d    = {word_q[W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (word_cnt_q == LAST_WORD) begin
                        if (sel_cnt_d == K_C) begin
                            state_d     = S_DONE;
                            index_vld_d = 1'b1;
                        end else begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 4'd1;
                        state_d    = S_WAIT_WORD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign index_o       = index_q;
    assign index_valid_o = index_vld_q;
    assign sel_cnt_o     = sel_cnt_q;
    assign fail_o        = fail_q;
    assign busy_o        = (state_q == S_WAIT_WORD) || (state_q == S_SCAN);

endmodule

// File: tb/tb_index_select.sv
// Bench for index_select: directed and random reliability streams, scoreboard-checked.
module tb_index_select;

    localparam int N = 450;
    localparam int W = 30;
    localparam int K = 256;
    localparam int NW = 15;
    localparam int BASE_LAT = 1 + NW * (1 + W) - 1;   // start edge to DONE edge

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           rel_valid = 1'b0;
    logic           rel_ready;
    logic [W-1:0]   rel_data = '0;
    logic [N-1:0]   index;
    logic           index_valid;
    logic [8:0]     sel_cnt;
    logic           busy;
    logic           fail;

    index_select #(.N(N), .W(W), .K(K)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start_i       (start),
        .rel_valid_i   (rel_valid),
        .rel_ready_o   (rel_ready),
        .rel_data_i    (rel_data),
        .index_o       (index),
        .index_valid_o (index_valid),
        .sel_cnt_o     (sel_cnt),
        .busy_o        (busy),
        .fail_o        (fail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] idx;
        int           cnt;
        bit           is_fail;
        int           start_cyc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    logic [W-1:0] words [NW];
    int           gaps  [NW];

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: walk positions in scan order, keep the first K reliable ones.
    function automatic void model(output logic [N-1:0] idx, output int cnt);
        idx = '0;
        cnt = 0;
        for (int p = 0; p < N; p++) begin
            if (words[p / W][W - 1 - (p % W)] && cnt < K) begin
                idx[N - 1 - p] = 1'b1;
                cnt++;
            end
        end
    endfunction

    // Monitor: consume one expectation per completion event (index_valid pulse or fail rising).
    bit fail_prev = 1'b0;
    bit iv_prev   = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            fail_prev = 1'b0;
            iv_prev   = 1'b0;
        end else begin
            if (iv_prev) chk("index_valid_one_cycle", N'(index_valid), N'(0));
            if (index_valid || (fail && !fail_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got index_valid=%0b fail=%0b expected no event",
                             index_valid, fail);
                end else begin
                    e = exp_q.pop_front();
                    chk("fail_flag",   N'(fail), N'(e.is_fail));
                    chk("index_valid", N'(index_valid), N'(!e.is_fail));
                    chk("index",       index, e.idx);
                    chk("sel_cnt",     N'(sel_cnt), N'(e.cnt));
                    chk("latency",     N'(cyc - e.start_cyc), N'(e.lat));
                    chk("busy_at_end", N'(busy), N'(0));
                end
            end
            fail_prev = fail;
            iv_prev   = index_valid;
        end
    end

    // Inputs change on the falling edge only.
    task automatic send_word(input logic [W-1:0] d, input int gap, input bit first, input bit pulse_start);
        int n = 0;
        start = pulse_start;
        while (!rel_ready && n < 100) begin
            @(negedge clk);
            n++;
            start = 1'b0;
        end
        start = 1'b0;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL rel_ready_timeout: got rel_ready=0 for %0d cycles expected 30", n);
        end else if (!first) begin
            chk("rel_ready_low_during_scan", N'(n), N'(W));
        end
        repeat (gap) @(negedge clk);
        rel_valid = 1'b1;
        rel_data  = d;
        @(negedge clk);
        rel_valid = 1'b0;
        rel_data  = W'($urandom);
    endtask

    task automatic run_case(input int mid_word, input int abort_word);
        exp_t e;
        int   s_cyc;
        int   n;
        int   gsum = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_cyc = cyc;
        chk("start_index_clear", index, '0);
        chk("start_sel_cnt",     N'(sel_cnt), N'(0));
        chk("start_fail_clear",  N'(fail), N'(0));
        chk("start_busy",        N'(busy), N'(1));
        if (abort_word < 0) begin
            for (int i = 0; i < NW; i++) gsum += gaps[i];
            model(e.idx, e.cnt);
            e.is_fail   = (e.cnt < K);
            e.start_cyc = s_cyc;
            e.lat       = BASE_LAT + gsum;
            exp_q.push_back(e);
        end
        for (int i = 0; i < NW; i++) begin
            send_word(words[i], gaps[i], i == 0, i == mid_word);
            if (i == abort_word) begin
                repeat (5) @(negedge clk);
                resetn = 1'b0;
                #1;
                chk("rst_index",       index, '0);
                chk("rst_sel_cnt",     N'(sel_cnt), N'(0));
                chk("rst_busy",        N'(busy), N'(0));
                chk("rst_fail",        N'(fail), N'(0));
                chk("rst_rel_ready",   N'(rel_ready), N'(0));
                chk("rst_index_valid", N'(index_valid), N'(0));
                @(negedge clk);
                resetn = 1'b1;
                @(negedge clk);
                return;
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: got no completion in %0d cycles expected one", n);
        end
        repeat (1 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic fill(input logic [W-1:0] first_w, input logic [W-1:0] rest_w, input int gap);
        for (int i = 0; i < NW; i++) begin
            words[i] = (i == 0) ? first_w : rest_w;
            gaps[i]  = gap;
        end
    endtask

    initial begin
        int dens;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_index",       index, '0);
        chk("reset_sel_cnt",     N'(sel_cnt), N'(0));
        chk("reset_busy",        N'(busy), N'(0));
        chk("reset_fail",        N'(fail), N'(0));
        chk("reset_rel_ready",   N'(rel_ready), N'(0));
        chk("reset_index_valid", N'(index_valid), N'(0));

        fill(30'h3FFFFFFF, 30'h3FFFFFFF, 0); run_case(-1, -1);   // all reliable
        fill(30'h0,        30'h3FFFFFFF, 0); run_case(-1, -1);   // first word unreliable
        fill(30'h2AAAAAAA, 30'h2AAAAAAA, 0); run_case(-1, -1);   // 225 ones: fails
        fill(30'h3FFFFFFF, 30'h3FFFFFFF, 3); run_case(-1, -1);   // 3 idle cycles per word
        fill(30'h3FFFFFFF, 30'h3FFFFFFF, 0); run_case(5, -1);    // start while busy
        fill(30'h0,        30'h3FFFFFFF, 0); run_case(-1, 7);    // reset mid-run
        fill(30'h0,        30'h3FFFFFFF, 0); run_case(-1, -1);   // clean rerun

        for (int r = 0; r < 10; r++) begin
            dens = $urandom_range(40, 80);
            for (int i = 0; i < NW; i++) begin
                for (int b = 0; b < W; b++) words[i][b] = ($urandom_range(0, 99) < dens);
                gaps[i] = $urandom_range(0, 4);
            end
            run_case((r % 3 == 0) ? int'($urandom_range(1, NW - 1)) : -1, -1);
        end

        chk("scoreboard_empty", N'(exp_q.size()), N'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
